// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs a 2-entry MDU result queue.
// Latency: pipeline write registered at the next edge; MDU result no earlier than one edge after acceptance.
// Backpressure: MDU_READY drops when the queue is full; STALL_PIPE holds the pipeline while a starved MDU result is forced out.
//
// Ports:
//   CLK, RESET                        clock, asynchronous active-high reset
//   PIPE_WE/PIPE_ADDR/PIPE_DATA       pipeline writeback request (single cycle)
//   MDU_VALID/MDU_ADDR/MDU_DATA       MDU result, handshaked with MDU_READY
//   CHECK_ADDR_1/2, HAZARD_1/2        decode-stage hazard check against pending MDU writes
//   STALL_PIPE                        pipeline must hold its writeback this cycle
//   WRITE_EN/WRITE_ADDR/WRITE_DATA    registered register-file write port
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_WE,
  input  logic [4:0]  PIPE_ADDR,
  input  logic [31:0] PIPE_DATA,
  input  logic        MDU_VALID,
  input  logic [4:0]  MDU_ADDR,
  input  logic [31:0] MDU_DATA,
  output logic        MDU_READY,
  input  logic [4:0]  CHECK_ADDR_1,
  input  logic [4:0]  CHECK_ADDR_2,
  output logic        HAZARD_1,
  output logic        HAZARD_2,
  output logic        STALL_PIPE,
  output logic        WRITE_EN,
  output logic [4:0]  WRITE_ADDR,
  output logic [31:0] WRITE_DATA
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  count, count_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic [4:0]  ent_addr [2];
  logic [31:0] ent_data [2];

  logic pipe_sel, pop, push;
  logic wr_idx;

  assign STALL_PIPE = (state == FORCE);
  // Readiness looks only at the current occupancy so it never depends on a same-cycle pop.
  assign MDU_READY  = !RESET && (count != 2'd2);

  assign pipe_sel = !STALL_PIPE && PIPE_WE && (PIPE_ADDR != 5'd0);
  assign pop      = !pipe_sel && (count != 2'd0);
  // x0 results complete the handshake but are dropped instead of queued.
  assign push     = MDU_VALID && MDU_READY && (MDU_ADDR != 5'd0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase

    // The counter measures how long the current head has been passed over.
    if (pop || count == 2'd0)
      wait_nxt = 4'd0;
    else
      wait_nxt = wait_cnt + 4'd1;

    if (count_nxt == 2'd0)
      state_nxt = IDLE;
    else if (wait_nxt == 4'(MAX_WAIT))
      state_nxt = FORCE;
    else
      state_nxt = WAIT;

    // Slot the new entry lands in, after any simultaneous pop has shifted the queue.
    wr_idx = ((count - {1'b0, pop}) != 2'd0);
  end

  always_comb begin
    HAZARD_1 = 1'b0;
    HAZARD_2 = 1'b0;
    if (CHECK_ADDR_1 != 5'd0)
      HAZARD_1 = (count != 2'd0 && ent_addr[0] == CHECK_ADDR_1) ||
                 (count == 2'd2 && ent_addr[1] == CHECK_ADDR_1) ||
                 (WRITE_EN && WRITE_ADDR == CHECK_ADDR_1);
    if (CHECK_ADDR_2 != 5'd0)
      HAZARD_2 = (count != 2'd0 && ent_addr[0] == CHECK_ADDR_2) ||
                 (count == 2'd2 && ent_addr[1] == CHECK_ADDR_2) ||
                 (WRITE_EN && WRITE_ADDR == CHECK_ADDR_2);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      count       <= 2'd0;
      wait_cnt    <= 4'd0;
      ent_addr[0] <= 5'd0;
      ent_addr[1] <= 5'd0;
      ent_data[0] <= 32'd0;
      ent_data[1] <= 32'd0;
      WRITE_EN    <= 1'b0;
      WRITE_ADDR  <= 5'd0;
      WRITE_DATA  <= 32'd0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      wait_cnt <= wait_nxt;

      if (pipe_sel) begin
        WRITE_EN   <= 1'b1;
        WRITE_ADDR <= PIPE_ADDR;
        WRITE_DATA <= PIPE_DATA;
      end else if (pop) begin
        WRITE_EN   <= 1'b1;
        WRITE_ADDR <= ent_addr[0];
        WRITE_DATA <= ent_data[0];
      end else begin
        WRITE_EN   <= 1'b0;
      end

      // Head is always slot 0; a pop shifts slot 1 forward.
      if (pop) begin
        ent_addr[0] <= ent_addr[1];
        ent_data[0] <= ent_data[1];
      end
      if (push) begin
        ent_addr[wr_idx] <= MDU_ADDR;
        ent_data[wr_idx] <= MDU_DATA;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIPE_WE = 1'b0;
  logic [4:0]  PIPE_ADDR = 5'd0;
  logic [31:0] PIPE_DATA = 32'd0;
  logic        MDU_VALID = 1'b0;
  logic [4:0]  MDU_ADDR = 5'd0;
  logic [31:0] MDU_DATA = 32'd0;
  logic        MDU_READY;
  logic [4:0]  CHECK_ADDR_1 = 5'd0;
  logic [4:0]  CHECK_ADDR_2 = 5'd0;
  logic        HAZARD_1, HAZARD_2, STALL_PIPE;
  logic        WRITE_EN;
  logic [4:0]  WRITE_ADDR;
  logic [31:0] WRITE_DATA;

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .PIPE_WE(PIPE_WE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
    .MDU_VALID(MDU_VALID), .MDU_ADDR(MDU_ADDR), .MDU_DATA(MDU_DATA), .MDU_READY(MDU_READY),
    .CHECK_ADDR_1(CHECK_ADDR_1), .CHECK_ADDR_2(CHECK_ADDR_2),
    .HAZARD_1(HAZARD_1), .HAZARD_2(HAZARD_2), .STALL_PIPE(STALL_PIPE),
    .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  int          m_wait = 0;    // cycles the current head has been passed over
  bit          m_en = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0;
  bit          m_stall, m_ready, m_pipe, m_nonempty;
  ent_t        m_head;

  function automatic bit model_hazard(input logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].a == c) return 1'b1;
    return m_en && (m_addr == c);
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      q.delete();
      m_wait = 0; m_en = 0; m_addr = 0; m_data = 0;
    end else begin
      m_nonempty = (q.size() != 0);
      m_stall    = m_nonempty && (m_wait == MAX_WAIT);
      m_ready    = (q.size() < 2);
      m_pipe     = !m_stall && PIPE_WE && (PIPE_ADDR != 0);
      if (m_pipe) begin
        m_en = 1; m_addr = PIPE_ADDR; m_data = PIPE_DATA;
        if (m_nonempty) m_wait++;
      end else if (m_nonempty) begin
        m_head = q.pop_front();
        m_en = 1; m_addr = m_head.a; m_data = m_head.d;
        m_wait = 0;
      end else begin
        m_en = 0;
        m_wait = 0;
      end
      if (MDU_VALID && m_ready && MDU_ADDR != 0)
        q.push_back('{a: MDU_ADDR, d: MDU_DATA});
    end
  end

  // Single compare process: every falling edge, DUT against model.
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      check("rst_write_en",   WRITE_EN,   0);
      check("rst_write_addr", WRITE_ADDR, 0);
      check("rst_write_data", WRITE_DATA, 0);
      check("rst_stall",      STALL_PIPE, 0);
      check("rst_hazard_1",   HAZARD_1,   0);
      check("rst_hazard_2",   HAZARD_2,   0);
      check("rst_mdu_ready",  MDU_READY,  0);
    end else if (RESET === 1'b0) begin
      check("write_en",   WRITE_EN,   m_en);
      check("write_addr", WRITE_ADDR, m_addr);
      check("write_data", WRITE_DATA, m_data);
      check("stall_pipe", STALL_PIPE, (q.size() != 0) && (m_wait == MAX_WAIT));
      check("mdu_ready",  MDU_READY,  q.size() < 2);
      check("hazard_1",   HAZARD_1,   model_hazard(CHECK_ADDR_1));
      check("hazard_2",   HAZARD_2,   model_hazard(CHECK_ADDR_2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    PIPE_WE = 0; MDU_VALID = 0;
    repeat (n) step();
  endtask

  initial begin
    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    #1;
    check("lit_ready_after_reset", MDU_READY, 1);
    idle(2);

    // Idle MDU result: visible one edge after acceptance, then gone.
    MDU_VALID = 1; MDU_ADDR = 5; MDU_DATA = 32'h0000_00AA;
    step();
    MDU_VALID = 0;
    check("lit_idle_no_bypass", WRITE_EN, 0);
    step();
    check("lit_idle_en",   WRITE_EN,   1);
    check("lit_idle_addr", WRITE_ADDR, 5);
    check("lit_idle_data", WRITE_DATA, 32'hAA);
    step();
    check("lit_idle_en_drop", WRITE_EN, 0);
    idle(2);

    // Contention: continuous pipeline writes to x3, one MDU result to x7.
    PIPE_WE = 1; PIPE_ADDR = 3; PIPE_DATA = 32'h3333;
    MDU_VALID = 1; MDU_ADDR = 7; MDU_DATA = 32'h7777;
    step();
    MDU_VALID = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("lit_cont_pipe_wins", WRITE_ADDR, 3);
      check("lit_cont_stall", STALL_PIPE, (i == 4));
    end
    step();
    check("lit_cont_forced_addr", WRITE_ADDR, 7);
    check("lit_cont_forced_data", WRITE_DATA, 32'h7777);
    check("lit_cont_stall_drop",  STALL_PIPE, 0);
    step();
    check("lit_cont_resume", WRITE_ADDR, 3);
    idle(3);

    // Full queue: third result held until after the first pop.
    PIPE_WE = 1; PIPE_ADDR = 3;
    MDU_VALID = 1; MDU_ADDR = 10; MDU_DATA = 32'hA0;
    step();
    MDU_ADDR = 11; MDU_DATA = 32'hB0;
    step();
    MDU_ADDR = 13; MDU_DATA = 32'hD0;
    check("lit_full_ready_lo", MDU_READY, 0);
    repeat (3) step();
    check("lit_full_ready_held", MDU_READY, 0);
    check("lit_full_stall", STALL_PIPE, 1);
    step();
    check("lit_full_first_pop", WRITE_ADDR, 10);
    check("lit_full_ready_back", MDU_READY, 1);
    step();
    MDU_VALID = 0;
    idle(12);

    // x0 filtering.
    PIPE_WE = 1; PIPE_ADDR = 3;
    MDU_VALID = 1; MDU_ADDR = 9; MDU_DATA = 32'h99;
    step();
    MDU_VALID = 0; PIPE_ADDR = 0;
    step();
    check("lit_x0_pipe_en",   WRITE_EN,   1);
    check("lit_x0_pipe_slot", WRITE_ADDR, 9);
    PIPE_WE = 0;
    MDU_VALID = 1; MDU_ADDR = 0; MDU_DATA = 32'hDEAD;
    step();
    MDU_VALID = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lit_x0_mdu_no_write", WRITE_EN, 0);
    end
    check("lit_x0_mdu_ready", MDU_READY, 1);
    idle(2);

    // Hazard on a queued entry.
    CHECK_ADDR_1 = 12; CHECK_ADDR_2 = 0;
    PIPE_WE = 1; PIPE_ADDR = 3;
    MDU_VALID = 1; MDU_ADDR = 12; MDU_DATA = 32'hC0;
    step();
    MDU_VALID = 0;
    check("lit_haz_1_set", HAZARD_1, 1);
    check("lit_haz_2_clr", HAZARD_2, 0);
    PIPE_WE = 0;
    step();
    check("lit_haz_written", WRITE_ADDR, 12);
    step();
    check("lit_haz_1_clear", HAZARD_1, 0);
    CHECK_ADDR_1 = 0;
    idle(2);

    // Reset mid-queue.
    PIPE_WE = 1; PIPE_ADDR = 3;
    MDU_VALID = 1; MDU_ADDR = 20; MDU_DATA = 32'h20;
    step();
    MDU_ADDR = 21; MDU_DATA = 32'h21;
    step();
    MDU_VALID = 0; PIPE_WE = 0;
    #2 RESET = 1'b1;
    #1;
    check("lit_rst_async_en",    WRITE_EN,   0);
    check("lit_rst_async_ready", MDU_READY,  0);
    step();
    step();
    RESET = 1'b0;
    #1;
    check("lit_rst_release_ready", MDU_READY, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lit_rst_no_write", WRITE_EN, 0);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      PIPE_WE      = ($urandom_range(0, 2) != 0);
      PIPE_ADDR    = 5'($urandom_range(0, 7));
      PIPE_DATA    = $urandom;
      MDU_VALID    = $urandom_range(0, 1) == 1;
      MDU_ADDR     = 5'($urandom_range(0, 7));
      MDU_DATA     = $urandom;
      CHECK_ADDR_1 = 5'($urandom_range(0, 7));
      CHECK_ADDR_2 = 5'($urandom_range(0, 7));
      RESET        = ($urandom_range(0, 199) == 0);
      step();
    end
    RESET = 1'b0;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
